// File: rtl/cpu19_mem_arbiter.sv
// cpu19 memory arbiter: shares one memory port between fetch, lsu and FFT.
// Round-robin grant with a bounded FFT burst lock and tagged read return.
module cpu19_mem_arbiter #(
    parameter int DW       = 19,
    parameter int AW       = 19,
    parameter int MAX_LOCK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      req,
    input  logic [2:0]      we,
    input  logic [3*AW-1:0] addr,
    input  logic [3*DW-1:0] wdata,
    input  logic            fft_lock,
    output logic [2:0]      gnt,
    output logic [2:0]      rvalid,
    output logic [DW-1:0]   rdata,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKED,
        COOLDOWN
    } lock_state_t;

    localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

    lock_state_t state, state_nxt;
    logic [7:0]  lock_cnt, lock_cnt_nxt;
    logic [1:0]  last;
    logic [1:0]  win;
    logic        found;
    logic        fft_gnt;

    function automatic logic [1:0] rr_idx(input logic [1:0] l, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, l} + {1'b0, k} + 3'd1;
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // Cooldown pushes FFT behind fetch/lsu by skipping it in the first scan
    always_comb begin : arb
        logic [1:0] idx;
        idx   = '0;
        win   = '0;
        found = 1'b0;
        if (state == LOCKED && req[2]) begin
            win   = 2'd2;
            found = 1'b1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                idx = rr_idx(last, 2'(k));
                if (!found && req[idx] && !(state == COOLDOWN && idx == 2'd2)) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
            if (!found && req[2]) begin
                win   = 2'd2;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        gnt       = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (found) begin
            gnt[win]  = 1'b1;
            mem_we    = we[win];
            mem_addr  = addr[win*AW +: AW];
            mem_wdata = wdata[win*DW +: DW];
        end
    end

    assign rdata   = mem_rdata;
    assign fft_gnt = found && (win == 2'd2);

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        unique case (state)
            UNLOCKED: begin
                if (fft_gnt && fft_lock) begin
                    lock_cnt_nxt = 8'd1;
                    state_nxt    = (LOCK_MAX == 8'd1) ? COOLDOWN : LOCKED;
                end
            end
            LOCKED: begin
                if (!req[2] || !fft_lock) begin
                    state_nxt    = UNLOCKED;
                    lock_cnt_nxt = '0;
                end else begin
                    lock_cnt_nxt = lock_cnt + 8'd1;
                    if (lock_cnt_nxt == LOCK_MAX) state_nxt = COOLDOWN;
                end
            end
            COOLDOWN: begin
                state_nxt    = UNLOCKED;
                lock_cnt_nxt = '0;
            end
            default: begin
                state_nxt    = UNLOCKED;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last     <= 2'd2;
            rvalid   <= '0;
            state    <= UNLOCKED;
            lock_cnt <= '0;
        end else begin
            if (found) last <= win;
            rvalid   <= (found && !we[win]) ? gnt : 3'b000;
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_cpu19_mem_arbiter.sv
// Testbench for cpu19_mem_arbiter: vector table plus read-return scoreboard.
// Memory is modelled as a registered address-hash so rdata is traceable.
module tb_cpu19_mem_arbiter;

    localparam int DW = 19;
    localparam int AW = 19;
    localparam int ML = 4;
    localparam logic [DW-1:0] K = 19'h2A5A5;

    logic            clk      = 1'b0;
    logic            reset    = 1'b0;
    logic [2:0]      req      = '0;
    logic [2:0]      we       = '0;
    logic            fft_lock = 1'b0;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt;
    logic [2:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    logic [AW-1:0] pa [3] = '{19'h00010, 19'h00200, 19'h40404};
    logic [DW-1:0] pw [3] = '{19'h12345, 19'h7FFFF, 19'h55555};

    assign addr  = {pa[2], pa[1], pa[0]};
    assign wdata = {pw[2], pw[1], pw[0]};

    cpu19_mem_arbiter #(.DW(DW), .AW(AW), .MAX_LOCK(ML)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .fft_lock  (fft_lock),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem_addr ^ K;

    typedef struct packed {
        logic       rst;
        logic [2:0] req;
        logic [2:0] we;
        logic       lock;
        logic [2:0] gnt;
    } vec_t;

    typedef struct packed {
        logic [2:0]    rv;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t exp_q[$];
    vec_t vt[27];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int oh_idx(input logic [2:0] g);
        return g[2] ? 2 : (g[1] ? 1 : 0);
    endfunction

    task automatic do_reset();
        reset    = 1'b1;
        req      = '0;
        we       = '0;
        fft_lock = 1'b0;
        #1;
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_q.push_back('{rv: 3'b000, rd: '0});
    endtask

    task automatic run_vec(input vec_t v, input int id);
        exp_t e;
        int   i;
        if (v.rst) do_reset();
        req      = v.req;
        we       = v.we;
        fft_lock = v.lock;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL v%0d_queue: got empty expected entry", id);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("v%0d_rvalid", id), 32'(rvalid), 32'(e.rv));
            if (e.rv != 3'b000)
                chk($sformatf("v%0d_rdata", id), 32'(rdata), 32'(e.rd));
        end
        i = oh_idx(v.gnt);
        chk($sformatf("v%0d_gnt", id), 32'(gnt), 32'(v.gnt));
        chk($sformatf("v%0d_mem_we", id), 32'(mem_we),
            (v.gnt != 0) ? 32'(v.we[i]) : 32'd0);
        chk($sformatf("v%0d_mem_addr", id), 32'(mem_addr),
            (v.gnt != 0) ? 32'(pa[i]) : 32'd0);
        chk($sformatf("v%0d_mem_wdata", id), 32'(mem_wdata),
            (v.gnt != 0) ? 32'(pw[i]) : 32'd0);
        e.rv = (v.gnt != 0 && !v.we[i]) ? v.gnt : 3'b000;
        e.rd = pa[i] ^ K;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst, req, we, lock, expected gnt
        vt[0]  = '{1'b1, 3'b000, 3'b000, 1'b0, 3'b000};
        vt[1]  = '{1'b0, 3'b000, 3'b000, 1'b0, 3'b000};
        vt[2]  = '{1'b0, 3'b000, 3'b000, 1'b0, 3'b000};
        vt[3]  = '{1'b0, 3'b001, 3'b000, 1'b0, 3'b001};
        vt[4]  = '{1'b0, 3'b000, 3'b000, 1'b0, 3'b000};
        vt[5]  = '{1'b0, 3'b010, 3'b010, 1'b0, 3'b010};
        vt[6]  = '{1'b0, 3'b000, 3'b000, 1'b0, 3'b000};
        vt[7]  = '{1'b1, 3'b111, 3'b000, 1'b0, 3'b001};
        vt[8]  = '{1'b0, 3'b111, 3'b000, 1'b0, 3'b010};
        vt[9]  = '{1'b0, 3'b111, 3'b000, 1'b0, 3'b100};
        vt[10] = '{1'b0, 3'b111, 3'b000, 1'b0, 3'b001};
        vt[11] = '{1'b0, 3'b111, 3'b000, 1'b0, 3'b010};
        vt[12] = '{1'b0, 3'b111, 3'b000, 1'b0, 3'b100};
        vt[13] = '{1'b0, 3'b000, 3'b000, 1'b0, 3'b000};
        vt[14] = '{1'b1, 3'b111, 3'b000, 1'b1, 3'b001};
        vt[15] = '{1'b0, 3'b111, 3'b000, 1'b1, 3'b010};
        vt[16] = '{1'b0, 3'b111, 3'b000, 1'b1, 3'b100};
        vt[17] = '{1'b0, 3'b111, 3'b000, 1'b1, 3'b100};
        vt[18] = '{1'b0, 3'b111, 3'b000, 1'b1, 3'b100};
        vt[19] = '{1'b0, 3'b111, 3'b000, 1'b1, 3'b100};
        vt[20] = '{1'b0, 3'b111, 3'b000, 1'b1, 3'b001};
        vt[21] = '{1'b0, 3'b111, 3'b000, 1'b1, 3'b010};
        vt[22] = '{1'b0, 3'b111, 3'b000, 1'b1, 3'b100};
        vt[23] = '{1'b0, 3'b011, 3'b000, 1'b1, 3'b001};
        vt[24] = '{1'b0, 3'b111, 3'b010, 1'b0, 3'b010};
        vt[25] = '{1'b0, 3'b111, 3'b000, 1'b0, 3'b100};
        vt[26] = '{1'b0, 3'b111, 3'b000, 1'b0, 3'b001};

        #2;
        for (int i = 0; i < 27; i++) run_vec(vt[i], i);

        // Reset lands between an FFT lock-read grant and its return edge
        do_reset();
        req      = 3'b100;
        we       = 3'b000;
        fft_lock = 1'b1;
        @(negedge clk);
        chk("mid_gnt", 32'(gnt), 32'b100);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rvalid_async", 32'(rvalid), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rvalid_held", 32'(rvalid), 32'd0);
        reset = 1'b0;
        req   = 3'b111;
        @(negedge clk);
        chk("post_rvalid", 32'(rvalid), 32'd0);
        chk("post_gnt_unlocked", 32'(gnt), 32'b001);
        @(posedge clk);
        #1;
        req = 3'b000;
        @(negedge clk);
        chk("post_rvalid_read", 32'(rvalid), 32'b001);
        chk("post_rdata", 32'(rdata), 32'(pa[0] ^ K));
        chk("post_idle_gnt", 32'(gnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
